// File: rtl/num_digit_scan_driver.sv
// Multiplexed hex display driver. A free-running prescaler divides each
// digit slot into 2^DIV_BITS cycles and steps through the digits one slot
// at a time. New display data is staged in pending registers and is only
// swapped into the active set on a frame boundary, so a frame never shows
// a mix of old and new data. The brightness PWM compares the top prescaler
// bits with a brightness code that is sampled once per slot.
//
// Handshake: load is a one-cycle request. It captures value/dp/blank_mask
// into the pending set in that cycle; a later load replaces data that has
// not been shown yet. load_ack pulses for one cycle, together with
// frame_start, when pending data moves into the active set. There is no
// ready signal, because a load is always accepted.
module num_digit_scan_driver #(
   parameter int NUM_DIGITS = 8,
   parameter int DIV_BITS   = 17,
   parameter int PWM_BITS   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   input  logic                      load,
   input  logic                      en,
   input  logic [PWM_BITS-1:0]       brightness,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     segdriv,
   output logic                      load_ack,
   output logic                      frame_start
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_BITS-1:0]     cnt;
   logic [IDX_W-1:0]        idx;
   logic [PWM_BITS-1:0]     bright_q;

   logic                    pend_flag;
   logic [4*NUM_DIGITS-1:0] pend_value;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   pend_blank;
   logic [4*NUM_DIGITS-1:0] act_value;
   logic [NUM_DIGITS-1:0]   act_dp;
   logic [NUM_DIGITS-1:0]   act_blank;

   logic                    tick;
   logic                    boundary;
   logic                    commit;
   logic [PWM_BITS-1:0]     slice;
   logic [3:0]              nib;
   logic                    dp_cur;
   logic                    blank_cur;
   logic                    lit;
   logic [6:0]              dec;
   logic [7:0]              seg_nxt;
   logic [NUM_DIGITS-1:0]   segdriv_nxt;

   assign tick     = &cnt;
   assign boundary = tick && (idx == LAST_IDX);
   assign commit   = boundary && pend_flag;
   assign slice    = cnt[DIV_BITS-1 -: PWM_BITS];

   // Pick the active nibble, decimal point and blank bit of the current digit.
   always_comb begin
      nib       = 4'h0;
      dp_cur    = 1'b0;
      blank_cur = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nib       = act_value[4*k +: 4];
            dp_cur    = act_dp[k];
            blank_cur = act_blank[k];
         end
      end
   end

   // Hex to active-high abcdefg segment pattern (bit 0 = segment a).
   always_comb begin
      dec = 7'h00;
      case (nib)
         4'h0: dec = 7'h3F;
         4'h1: dec = 7'h06;
         4'h2: dec = 7'h5B;
         4'h3: dec = 7'h4F;
         4'h4: dec = 7'h66;
         4'h5: dec = 7'h6D;
         4'h6: dec = 7'h7D;
         4'h7: dec = 7'h07;
         4'h8: dec = 7'h7F;
         4'h9: dec = 7'h6F;
         4'hA: dec = 7'h77;
         4'hB: dec = 7'h7C;
         4'hC: dec = 7'h39;
         4'hD: dec = 7'h5E;
         4'hE: dec = 7'h79;
         4'hF: dec = 7'h71;
         default: dec = 7'h00;
      endcase
   end

   // Next output pattern: a single active-low digit enable, or fully dark.
   always_comb begin
      lit         = en && !blank_cur && (slice <= bright_q);
      seg_nxt     = 8'hFF;
      segdriv_nxt = '1;
      if (lit) begin
         seg_nxt     = {~dp_cur, ~dec};
         segdriv_nxt = ~(NUM_DIGITS'(1) << idx);
      end
   end

   // Scan timing: prescaler, digit index, per-slot brightness sample, frame pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= '0;
         bright_q    <= '0;
         frame_start <= 1'b0;
      end else begin
         cnt         <= cnt + 1'b1;
         frame_start <= boundary;
         if (tick) begin
            idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            bright_q <= brightness;
         end
      end
   end

   // Stage loaded data, then swap it into the active set on a frame boundary.
   // A load on the boundary cycle still lets the older pending data commit,
   // because the active copy reads the pending registers before they update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_flag  <= 1'b0;
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_value  <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         load_ack   <= 1'b0;
      end else begin
         load_ack <= commit;
         if (commit) begin
            act_value <= pend_value;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
         end
         if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_blank <= blank_mask;
            pend_flag  <= 1'b1;
         end else if (commit) begin
            pend_flag  <= 1'b0;
         end
      end
   end

   // Registered display outputs, one cycle behind the scan counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg     <= 8'hFF;
         segdriv <= '1;
      end else begin
         seg     <= seg_nxt;
         segdriv <= segdriv_nxt;
      end
   end

endmodule

// File: tb/tb_num_digit_scan_driver.sv
// Bench for num_digit_scan_driver with 4 digits, 16-cycle slots and a
// 2-bit brightness code. Whole frames are sampled on the falling edge and
// summarised per slot; the summaries are compared against hand-computed
// frame contents.
module tb_num_digit_scan_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp = 4'b0000;
   logic [3:0]  blank_mask = 4'b0000;
   logic        load = 1'b0;
   logic        en = 1'b1;
   logic [1:0]  brightness = 2'd3;
   logic [7:0]  seg;
   logic [3:0]  segdriv;
   logic        load_ack;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   // Per-frame summary filled by run_frame.
   int         lit_cnt[4];
   logic [7:0] seg_seen[4];
   int         fs_cnt;
   int         ack_cnt;
   int         ack_fs;
   int         bad;
   int         wait_acks;

   num_digit_scan_driver #(
      .NUM_DIGITS(4),
      .DIV_BITS(4),
      .PWM_BITS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .value(value),
      .dp(dp),
      .blank_mask(blank_mask),
      .load(load),
      .en(en),
      .brightness(brightness),
      .seg(seg),
      .segdriv(segdriv),
      .load_ack(load_ack),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until the sample that shows frame_start; counts load_ack on the way.
   task automatic wait_frame_start(input string tag);
      int found;
      found = 0;
      wait_acks = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (load_ack) wait_acks++;
         if (frame_start) begin
            found = 1;
            break;
         end
      end
      check({tag, "_fs_found"}, found, 1);
   endtask

   // Sample one frame (64 cycles) starting right after a frame_start sample.
   // Optional loads are driven at sample indices la and lb (-1 = none).
   task automatic run_frame(input int la, input logic [15:0] va, input logic [3:0] da,
                            input logic [3:0] ba, input int lb, input logic [15:0] vb,
                            input logic [3:0] db, input logic [3:0] bb);
      logic [3:0] one;
      logic [3:0] exp_drv;
      int         s;
      one     = 4'b0001;
      fs_cnt  = 0;
      ack_cnt = 0;
      ack_fs  = 0;
      bad     = 0;
      for (int k = 0; k < 4; k++) begin
         lit_cnt[k]  = 0;
         seg_seen[k] = 8'hFF;
      end
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (load) begin
            load  = 1'b0;
            value = 16'hEEEE;
         end
         s       = i / 16;
         exp_drv = ~(one << s);
         if (segdriv == exp_drv) begin
            lit_cnt[s]++;
            if (seg_seen[s] != 8'hFF && seg != seg_seen[s]) bad++;
            seg_seen[s] = seg;
         end else if (segdriv != 4'hF) begin
            bad++;
         end else if (seg != 8'hFF) begin
            bad++;
         end
         if (frame_start) fs_cnt++;
         if (load_ack) ack_cnt++;
         if (load_ack && frame_start) ack_fs++;
         if (i == la) begin
            value = va; dp = da; blank_mask = ba; load = 1'b1;
         end else if (i == lb) begin
            value = vb; dp = db; blank_mask = bb; load = 1'b1;
         end
      end
   endtask

   task automatic check_frame(input string tag, input int l0, input int l1, input int l2,
                              input int l3, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3, input int acks);
      check({tag, "_lit0"}, lit_cnt[0], l0);
      check({tag, "_lit1"}, lit_cnt[1], l1);
      check({tag, "_lit2"}, lit_cnt[2], l2);
      check({tag, "_lit3"}, lit_cnt[3], l3);
      check({tag, "_seg0"}, seg_seen[0], s0);
      check({tag, "_seg1"}, seg_seen[1], s1);
      check({tag, "_seg2"}, seg_seen[2], s2);
      check({tag, "_seg3"}, seg_seen[3], s3);
      check({tag, "_fs"}, fs_cnt, 1);
      check({tag, "_ack"}, ack_cnt, acks);
      check({tag, "_ack_with_fs"}, ack_fs, acks);
      check({tag, "_glitch"}, bad, 0);
   endtask

   initial begin
      // Reset held over several clock edges.
      repeat (3) @(negedge clk);
      check("rst_seg", seg, 8'hFF);
      check("rst_segdriv", segdriv, 4'hF);
      check("rst_ack", load_ack, 1'b0);
      check("rst_fs", frame_start, 1'b0);
      reset = 1'b0;

      // First frame has a dim slot 0 (brightness not yet sampled); skip it.
      wait_frame_start("start");
      check("start_acks", wait_acks, 0);

      // All zeros at full brightness; load 8A3F mid-frame, must not show yet.
      run_frame(20, 16'h8A3F, 4'b0001, 4'b0000, -1, 16'h0, 4'h0, 4'h0);
      check_frame("zeros", 16, 16, 16, 16, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1);

      // 8A3F visible; load 0123 mid-frame, then 4567 on the boundary cycle.
      run_frame(30, 16'h0123, 4'b0000, 4'b0000, 62, 16'h4567, 4'b1111, 4'b0000);
      check_frame("8a3f", 16, 16, 16, 16, 8'h0E, 8'hB0, 8'h88, 8'h80, 1);

      // 0123 committed by that boundary; 4567 deferred to the next one.
      run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      check_frame("0123", 16, 16, 16, 16, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 1);

      // Brightness 0 set after the boundary tick: slot 0 keeps the old level.
      brightness = 2'd0;
      run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      check_frame("bright0", 16, 4, 4, 4, 8'h78, 8'h02, 8'h12, 8'h19, 0);

      // Brightness 1; also stage a blank on digit 2.
      brightness = 2'd1;
      run_frame(10, 16'h4567, 4'b1111, 4'b0100, -1, 16'h0, 4'h0, 4'h0);
      check_frame("bright1", 4, 8, 8, 8, 8'h78, 8'h02, 8'h12, 8'h19, 1);

      // Blank committed; full brightness from slot 1 on.
      brightness = 2'd3;
      run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      check_frame("blank2", 8, 16, 0, 16, 8'h78, 8'h02, 8'hFF, 8'h19, 0);

      // Display disabled: fully dark, frame pulses continue.
      en = 1'b0;
      run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      check_frame("en_off", 0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);

      // Asynchronous reset mid-slot with a pending load.
      en = 1'b1;
      repeat (4) @(negedge clk);
      check("pre_rst_segdriv", segdriv, 4'hE);
      value = 16'h1111; dp = 4'b1111; blank_mask = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_rst_seg", seg, 8'hFF);
      check("async_rst_segdriv", segdriv, 4'hF);
      repeat (3) @(negedge clk);
      check("rst_hold_seg", seg, 8'hFF);
      check("rst_hold_segdriv", segdriv, 4'hF);
      check("rst_hold_fs", frame_start, 1'b0);
      reset = 1'b0;
      wait_frame_start("post_rst");
      check("post_rst_acks", wait_acks, 0);
      run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      check_frame("post_rst", 16, 16, 16, 16, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
